// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: recovers pixel coordinates from hsync/vsync/video_on,
// measures line and frame geometry, and locks once consecutive frames match the parameters.
module vga_timing_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_DISPLAY   = 640,
  parameter int unsigned V_DISPLAY   = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t     state, state_next;
  logic       hs_q, vs_q, von_q;
  logic [9:0] h_cnt, v_cnt;
  logic       h_valid, line_bad;
  logic [2:0] good_cnt, good_cnt_next;
  logic       locked_next, sync_err_next;

  logic       hs_fall, vs_fall, von_rise, von_fall;
  logic [9:0] h_cnt_inc, v_cnt_inc, px_inc, frame_lines_new, pixel_y_final;
  logic       line_bad_new, frame_good;

  function automatic logic [9:0] sat_inc(input logic [9:0] val);
    return (val == '1) ? val : val + 10'd1;
  endfunction

  // Edge strobes are qualified by p_tick so every consumer only acts on sampling ticks.
  assign hs_fall  = p_tick & hs_q & ~hsync;
  assign vs_fall  = p_tick & vs_q & ~vsync;
  assign von_rise = p_tick & ~von_q & video_on;
  assign von_fall = p_tick & von_q & ~video_on;

  always_comb begin
    h_cnt_inc       = sat_inc(h_cnt);
    v_cnt_inc       = sat_inc(v_cnt);
    px_inc          = sat_inc(pixel_x);
    frame_lines_new = hs_fall ? v_cnt_inc : v_cnt;
    pixel_y_final   = von_fall ? sat_inc(pixel_y) : pixel_y;
    // Violations seen on the vs_fall tick itself still count against the closing frame.
    line_bad_new    = line_bad |
                      (h_valid & ((hs_fall  & (h_cnt_inc != 10'(H_TOTAL))) |
                                  (von_fall & (px_inc    != 10'(H_DISPLAY)))));
    frame_good      = ~line_bad_new &
                      (frame_lines_new == 10'(V_TOTAL)) &
                      (pixel_y_final   == 10'(V_DISPLAY));
  end

  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    locked_next   = locked;
    sync_err_next = 1'b0;
    if (vs_fall) begin
      case (state)
        SEARCH: begin
          state_next    = ACQUIRE;
          good_cnt_next = '0;
        end
        ACQUIRE: begin
          if (frame_good) begin
            good_cnt_next = good_cnt + 3'd1;
            if (good_cnt + 3'd1 == 3'(LOCK_FRAMES)) begin
              state_next  = LOCKED;
              locked_next = 1'b1;
            end
          end else begin
            good_cnt_next = '0;
          end
        end
        LOCKED: begin
          if (!frame_good) begin
            state_next    = ACQUIRE;
            good_cnt_next = '0;
            locked_next   = 1'b0;
            sync_err_next = 1'b1;
          end
        end
        default: begin
          state_next    = SEARCH;
          good_cnt_next = '0;
          locked_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
      locked   <= locked_next;
      sync_err <= sync_err_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      von_q       <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_valid     <= 1'b0;
      line_bad    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else if (p_tick) begin
      hs_q  <= hsync;
      vs_q  <= vsync;
      von_q <= video_on;

      if (hs_fall) begin
        line_len <= h_cnt_inc;
        h_cnt    <= '0;
        h_valid  <= 1'b1;
      end else begin
        h_cnt <= h_cnt_inc;
      end

      if (vs_fall) begin
        frame_lines <= frame_lines_new;
        v_cnt       <= '0;
        line_bad    <= 1'b0;
        pixel_y     <= '0;
      end else begin
        if (hs_fall)  v_cnt   <= v_cnt_inc;
        if (von_fall) pixel_y <= pixel_y_final;
        line_bad <= line_bad_new;
      end

      if (von_rise)      pixel_x <= '0;
      else if (video_on) pixel_x <= px_inc;
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced 20x10 (12x6 active) raster,
// p_tick one clk in four; vsync falls at the first tick of each generated frame.
module tb_vga_timing_monitor;

  logic       clk = 1'b0;
  logic       reset, p_tick, hsync, vsync, video_on;
  logic [9:0] pixel_x, pixel_y, line_len, frame_lines;
  logic       locked, sync_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned err_cycles = 0;
  int unsigned e0;

  vga_timing_monitor #(
    .H_TOTAL(20), .V_TOTAL(10), .H_DISPLAY(12), .V_DISPLAY(6), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y), .line_len(line_len),
    .frame_lines(frame_lines), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sync_err === 1'b1) err_cycles++;

  // One pixel tick at raster position (v,h): hsync low h=14..15, vsync low v=0..1, active v=3..8,h<12.
  task automatic do_tick(input int unsigned v, input int unsigned h);
    @(negedge clk);
    hsync    = !(h == 14 || h == 15);
    vsync    = !(v == 0 || v == 1);
    video_on = (h < 12) && (v >= 3) && (v <= 8);
    p_tick   = 1'b1;
    @(negedge clk);
    p_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic gen_line(input int unsigned v, input int unsigned len, input int unsigned h0);
    for (int unsigned h = h0; h < len; h++) do_tick(v, h);
  endtask

  // Lines 0..n_lines-1 (line `stretch` is 21 ticks), then the first tick of the next frame.
  task automatic gen_frame(input int unsigned n_lines, input int unsigned stretch, input int unsigned h0);
    gen_line(0, (stretch == 0) ? 21 : 20, h0);
    for (int unsigned v = 1; v < n_lines; v++) gen_line(v, (v == stretch) ? 21 : 20, 0);
    do_tick(0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0; p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1; video_on = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (pixel_x !== 10'd0) $display("FAIL reset_pixel_x: got %0d want 0", pixel_x); else n_pass++;
    n_checks++; if (pixel_y !== 10'd0) $display("FAIL reset_pixel_y: got %0d want 0", pixel_y); else n_pass++;
    n_checks++; if (line_len !== 10'd0) $display("FAIL reset_line_len: got %0d want 0", line_len); else n_pass++;
    n_checks++; if (frame_lines !== 10'd0) $display("FAIL reset_frame_lines: got %0d want 0", frame_lines); else n_pass++;
    n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0d want 0", locked); else n_pass++;
    n_checks++; if (sync_err !== 1'b0) $display("FAIL reset_sync_err: got %0d want 0", sync_err); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_lock();
    e0 = err_cycles;
    gen_frame(10, 99, 0);
    n_checks++; if (locked !== 1'b0) $display("FAIL lock_after_1: got %0d want 0", locked); else n_pass++;
    gen_frame(10, 99, 1);
    n_checks++; if (locked !== 1'b1) $display("FAIL lock_after_2: got %0d want 1", locked); else n_pass++;
    n_checks++; if (line_len !== 10'd20) $display("FAIL lock_line_len: got %0d want 20", line_len); else n_pass++;
    n_checks++; if (frame_lines !== 10'd10) $display("FAIL lock_frame_lines: got %0d want 10", frame_lines); else n_pass++;
    n_checks++; if (err_cycles - e0 != 0) $display("FAIL lock_no_err: got %0d want 0", err_cycles - e0); else n_pass++;
  endtask

  task automatic test_pixel_coords();
    e0 = err_cycles;
    gen_line(0, 20, 1);
    gen_line(1, 20, 0);
    gen_line(2, 20, 0);
    do_tick(3, 0);
    n_checks++; if (pixel_x !== 10'd0) $display("FAIL first_px: got %0d want 0", pixel_x); else n_pass++;
    n_checks++; if (pixel_y !== 10'd0) $display("FAIL first_py: got %0d want 0", pixel_y); else n_pass++;
    gen_line(3, 20, 1);
    for (int unsigned v = 4; v < 8; v++) gen_line(v, 20, 0);
    for (int unsigned h = 0; h < 12; h++) do_tick(8, h);
    n_checks++; if (pixel_x !== 10'd11) $display("FAIL last_px: got %0d want 11", pixel_x); else n_pass++;
    n_checks++; if (pixel_y !== 10'd5) $display("FAIL last_py: got %0d want 5", pixel_y); else n_pass++;
    do_tick(8, 12);
    n_checks++; if (pixel_y !== 10'd6) $display("FAIL post_vfall_py: got %0d want 6", pixel_y); else n_pass++;
    n_checks++; if (pixel_x !== 10'd11) $display("FAIL post_vfall_px: got %0d want 11", pixel_x); else n_pass++;
    gen_line(8, 20, 13);
    gen_line(9, 20, 0);
    do_tick(0, 0);
    n_checks++; if (locked !== 1'b1) $display("FAIL pixel_frame_locked: got %0d want 1", locked); else n_pass++;
    n_checks++; if (err_cycles - e0 != 0) $display("FAIL pixel_frame_err: got %0d want 0", err_cycles - e0); else n_pass++;
  endtask

  task automatic test_stretch();
    e0 = err_cycles;
    gen_line(0, 20, 1);
    for (int unsigned v = 1; v < 4; v++) gen_line(v, 20, 0);
    gen_line(4, 21, 0);
    gen_line(5, 20, 0);
    n_checks++; if (line_len !== 10'd21) $display("FAIL stretch_line_len: got %0d want 21", line_len); else n_pass++;
    n_checks++; if (locked !== 1'b1) $display("FAIL stretch_mid_locked: got %0d want 1", locked); else n_pass++;
    for (int unsigned v = 6; v < 10; v++) gen_line(v, 20, 0);
    do_tick(0, 0);
    n_checks++; if (err_cycles - e0 != 1) $display("FAIL stretch_err_width: got %0d want 1", err_cycles - e0); else n_pass++;
    n_checks++; if (locked !== 1'b0) $display("FAIL stretch_unlock: got %0d want 0", locked); else n_pass++;
    n_checks++; if (sync_err !== 1'b0) $display("FAIL stretch_err_clear: got %0d want 0", sync_err); else n_pass++;
    gen_frame(10, 99, 1);
    n_checks++; if (locked !== 1'b0) $display("FAIL relock_1: got %0d want 0", locked); else n_pass++;
    gen_frame(10, 99, 1);
    n_checks++; if (locked !== 1'b1) $display("FAIL relock_2: got %0d want 1", locked); else n_pass++;
    n_checks++; if (line_len !== 10'd20) $display("FAIL relock_line_len: got %0d want 20", line_len); else n_pass++;
  endtask

  task automatic test_short_frame();
    e0 = err_cycles;
    gen_frame(9, 99, 1);
    n_checks++; if (frame_lines !== 10'd9) $display("FAIL short_locked_lines: got %0d want 9", frame_lines); else n_pass++;
    n_checks++; if (locked !== 1'b0) $display("FAIL short_unlock: got %0d want 0", locked); else n_pass++;
    n_checks++; if (err_cycles - e0 != 1) $display("FAIL short_err: got %0d want 1", err_cycles - e0); else n_pass++;
    gen_frame(10, 99, 1);
    n_checks++; if (frame_lines !== 10'd10) $display("FAIL acq_good_lines: got %0d want 10", frame_lines); else n_pass++;
    gen_frame(9, 99, 1);
    n_checks++; if (frame_lines !== 10'd9) $display("FAIL acq_short_lines: got %0d want 9", frame_lines); else n_pass++;
    n_checks++; if (err_cycles - e0 != 1) $display("FAIL acq_no_err: got %0d want 1", err_cycles - e0); else n_pass++;
    gen_frame(10, 99, 1);
    n_checks++; if (locked !== 1'b0) $display("FAIL acq_cnt_cleared: got %0d want 0", locked); else n_pass++;
    gen_frame(10, 99, 1);
    n_checks++; if (locked !== 1'b1) $display("FAIL acq_relock: got %0d want 1", locked); else n_pass++;
  endtask

  task automatic test_ptick_hold();
    e0 = err_cycles;
    for (int unsigned h = 1; h < 6; h++) do_tick(0, h);
    for (int unsigned i = 0; i < 50; i++) begin
      @(negedge clk);
      p_tick   = 1'b0;
      hsync    = ~hsync;
      vsync    = (i % 3) != 0;
      video_on = (i % 2) != 0;
    end
    n_checks++; if (pixel_x !== 10'd11) $display("FAIL hold_px: got %0d want 11", pixel_x); else n_pass++;
    n_checks++; if (pixel_y !== 10'd0) $display("FAIL hold_py: got %0d want 0", pixel_y); else n_pass++;
    n_checks++; if (line_len !== 10'd20) $display("FAIL hold_line_len: got %0d want 20", line_len); else n_pass++;
    n_checks++; if (frame_lines !== 10'd10) $display("FAIL hold_frame_lines: got %0d want 10", frame_lines); else n_pass++;
    n_checks++; if (locked !== 1'b1) $display("FAIL hold_locked: got %0d want 1", locked); else n_pass++;
    gen_line(0, 20, 6);
    for (int unsigned v = 1; v < 10; v++) gen_line(v, 20, 0);
    do_tick(0, 0);
    n_checks++; if (locked !== 1'b1) $display("FAIL hold_after_locked: got %0d want 1", locked); else n_pass++;
    n_checks++; if (line_len !== 10'd20) $display("FAIL hold_after_line_len: got %0d want 20", line_len); else n_pass++;
    n_checks++; if (err_cycles - e0 != 0) $display("FAIL hold_after_err: got %0d want 0", err_cycles - e0); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    gen_line(0, 20, 1);
    for (int unsigned v = 1; v < 4; v++) gen_line(v, 20, 0);
    for (int unsigned h = 0; h < 6; h++) do_tick(4, h);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (pixel_x !== 10'd0) $display("FAIL rst_mid_px: got %0d want 0", pixel_x); else n_pass++;
    n_checks++; if (pixel_y !== 10'd0) $display("FAIL rst_mid_py: got %0d want 0", pixel_y); else n_pass++;
    n_checks++; if (line_len !== 10'd0) $display("FAIL rst_mid_line_len: got %0d want 0", line_len); else n_pass++;
    n_checks++; if (frame_lines !== 10'd0) $display("FAIL rst_mid_frame_lines: got %0d want 0", frame_lines); else n_pass++;
    n_checks++; if (locked !== 1'b0) $display("FAIL rst_mid_locked: got %0d want 0", locked); else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int unsigned h = 6; h < 20; h++) do_tick(4, h);
    for (int unsigned v = 5; v < 10; v++) gen_line(v, 20, 0);
    do_tick(0, 0);
    n_checks++; if (locked !== 1'b0) $display("FAIL rst_first_vs: got %0d want 0", locked); else n_pass++;
    gen_frame(10, 99, 1);
    n_checks++; if (locked !== 1'b0) $display("FAIL rst_good_1: got %0d want 0", locked); else n_pass++;
    gen_frame(10, 99, 1);
    n_checks++; if (locked !== 1'b1) $display("FAIL rst_good_2: got %0d want 1", locked); else n_pass++;
    n_checks++; if (frame_lines !== 10'd10) $display("FAIL rst_frame_lines: got %0d want 10", frame_lines); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixel_coords();
    test_stretch();
    test_short_frame();
    test_ptick_hold();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receive-side counterpart of the team's VGA sync generator.
- Samples hsync/vsync/video_on on the pixel tick and recovers pixel_x/pixel_y.
- Measures line length and frame height, and declares lock once timing matches 640x480@60 (800x525 total).
- Used as an on-chip checker in the Pong build, and as the sink side when verifying the timing generator.

Parameters:
H_TOTAL, 800, expected pixel ticks between consecutive hsync falling edges
V_TOTAL, 525, expected hsync falling edges between consecutive vsync falling edges
H_DISPLAY, 640, expected video_on-high ticks per active line
V_DISPLAY, 480, expected active lines per frame
LOCK_FRAMES, 2, consecutive good frames needed to assert locked (1..7)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
p_tick  in  1  pixel-rate enable, one clk wide
hsync  in  1  horizontal sync, active-low pulse
vsync  in  1  vertical sync, active-low pulse
video_on  in  1  active-video qualifier
pixel_x  out  10  recovered column of the most recently sampled active pixel
pixel_y  out  10  recovered row (active lines completed this frame)
line_len  out  10  last measured line length in ticks
frame_lines  out  10  last measured frame height in lines
locked  out  1  timing matches parameters
sync_err  out  1  one-clk pulse when a frame check fails while locked

Behaviour:
- reset=0 (async): all outputs 0, internal counters 0, h_valid=0, good_cnt=0, state SEARCH.
- All registers change only on clk edges with p_tick=1; otherwise hold. Outputs are registered, 1 clk after the sampling edge. sync_err is the only pulse output.
- Edge detects use the previous sampled value:
  - hs_fall: hsync 1->0; vs_fall: vsync 1->0.
  - von_rise / von_fall: video_on 0->1 / 1->0.
  - Previous-sample registers reset to 1 for hsync/vsync and 0 for video_on.
- h_cnt (10b, saturates at 1023):
  - On hs_fall: line_len <= h_cnt+1 (sat), h_cnt <= 0, h_valid <= 1.
  - Otherwise h_cnt increments.
- v_cnt (10b, saturating) increments on every hs_fall.
  - On vs_fall: frame_lines <= v_cnt (plus 1 if hs_fall on the same tick), v_cnt <= 0.
- pixel_x: 0 on von_rise; +1 on each later tick with video_on=1 (sat 1023); hold while video_on=0.
- pixel_y:
  - 0 on vs_fall.
  - +1 on von_fall, unless vs_fall occurs on the same tick (vs_fall wins).
- line_bad (sticky, cleared on vs_fall). Set when h_valid=1 and either:
  - hs_fall with h_cnt+1 != H_TOTAL, or
  - von_fall with pixel_x+1 != H_DISPLAY.
- Frame check at vs_fall (once pixel_x+1 on a same-tick von_fall and frame_lines are applied): good = !line_bad && new frame_lines==V_TOTAL && final pixel_y==V_DISPLAY.
- FSM:
  - SEARCH: on vs_fall -> ACQUIRE, good_cnt<=0. The frame check is ignored on this edge.
  - ACQUIRE, at vs_fall:
    - good: good_cnt+1. When good_cnt+1==LOCK_FRAMES -> LOCKED, locked<=1.
    - not good: good_cnt<=0, stay in ACQUIRE.
  - LOCKED, at vs_fall:
    - good: stay.
    - not good: sync_err<=1 for that clk, locked<=0, good_cnt<=0 -> ACQUIRE.
- Errors are only reported at frame boundaries. A vsync that never falls leaves state unchanged, with counters saturating.

Test Plan:
- Reference generator (800x525, 640x480 active), p_tick every 4 clk -> after the first vs_fall plus 2 full frames: locked=1, line_len=800, frame_lines=525, sync_err never asserted.
- Same stream, sample at the first/last active pixel of a frame -> pixel_x=0, pixel_y=0 / pixel_x=639, pixel_y=479; pixel_y=480 after the last von_fall.
- While locked, stretch one line to 801 ticks -> line_len=801 after that hs_fall; at the next vs_fall, sync_err=1 for exactly one clk and locked=0; re-locks 2 frames later.
- In ACQUIRE, one frame with 524 lines -> frame_lines=524, good_cnt cleared; locked asserts only after 2 further good frames.
- Hold p_tick=0 for 50 clk mid-line while toggling hsync -> all outputs unchanged.
- Drop reset mid-frame, asynchronous to clk -> all outputs 0 immediately; on release, locked stays 0 until the first vs_fall plus 2 good frames.
